// File: rtl/two_phase_pkg.sv
// Shared definitions for the two-phase toggle receive endpoint: channel-index
// width helper, legal parameter ranges and the per-channel status bundle.
package two_phase_pkg;

    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 8;
    localparam int SYNC_STAGES_MIN = 2;

    // Channel index width; a single channel still needs a 1-bit out_ch.
    function automatic int chW(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic pending;
        logic full;
    } chStatus_t;

endpackage

// File: rtl/two_phase_sync.sv
// One toggle channel front end: req synchroniser chain, last-seen phase and
// the pending flag (a req transition not yet captured).
module two_phase_sync
    import two_phase_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkB,
    input  logic rstB,
    input  logic reqA,
    input  logic capture,
    output logic pending
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_badSync
        $error("two_phase_sync: SYNC_STAGES below minimum");
    end

    logic [SYNC_STAGES-1:0] chain;
    logic                   seen;

    always_ff @(posedge clkB) begin
        if (rstB) begin
            chain <= '0;
            seen  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], reqA};
            if (capture)
                seen <= chain[SYNC_STAGES-1];
        end
    end

    assign pending = chain[SYNC_STAGES-1] ^ seen;

endmodule

// File: rtl/two_phase_hs_rx.sv
// Multi-channel two-phase receive endpoint merging captured words onto one
// round-robin valid/ready stream. Define TWO_PHASE_EARLY_ACK_EN to ack on capture.
module two_phase_hs_rx
    import two_phase_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int WIDTH       = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = chW(NUM_CH)
) (
    input  logic                    clkB,
    input  logic                    rstB,
    input  logic [NUM_CH-1:0]       ReqA,
    input  logic [NUM_CH*WIDTH-1:0] DataA,
    output logic [NUM_CH-1:0]       AckA,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_badNumCh
        $error("two_phase_hs_rx: NUM_CH out of range");
    end

    chStatus_t [NUM_CH-1:0]        status;
    logic [NUM_CH-1:0]             pendRaw;
    logic [NUM_CH-1:0]             full;
    logic [NUM_CH-1:0]             capture;
    logic [NUM_CH-1:0]             drain;
    logic [NUM_CH-1:0]             ackFlip;
    logic [NUM_CH-1:0][WIDTH-1:0]  hold;
    logic [CH_W-1:0]               rr;
    logic [CH_W-1:0]               rrSel;
    logic [CH_W-1:0]               sel;
    logic [CH_W-1:0]               lockCh;
    logic                          lockVld;
    logic                          accept;

    assign accept = out_valid & out_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        two_phase_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clkB    (clkB),
            .rstB    (rstB),
            .reqA    (ReqA[c]),
            .capture (capture[c]),
            .pending (pendRaw[c])
        );

        assign status[c]  = '{pending: pendRaw[c], full: full[c]};
        // A full channel blocks capture; the toggle simply stays pending.
        assign capture[c] = status[c].pending & ~status[c].full;
        assign drain[c]   = accept && (sel == CH_W'(c));

`ifdef TWO_PHASE_EARLY_ACK_EN
        assign ackFlip[c] = capture[c];
`else
        assign ackFlip[c] = drain[c];
`endif

        always_ff @(posedge clkB) begin
            if (rstB) begin
                full[c] <= 1'b0;
                AckA[c] <= 1'b0;
            end else begin
                if (capture[c])
                    full[c] <= 1'b1;
                else if (drain[c])
                    full[c] <= 1'b0;
                if (ackFlip[c])
                    AckA[c] <= ~AckA[c];
            end
        end

        always_ff @(posedge clkB) begin
            if (capture[c])
                hold[c] <= DataA[c*WIDTH +: WIDTH];
        end
    end

    if (NUM_CH == 1) begin : g_single
        assign rrSel = '0;
    end else begin : g_rr
        // Scan downward so the nearest full channel at or after rr wins.
        always_comb begin
            int idx;
            rrSel = rr;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                idx = (int'(rr) + i) % NUM_CH;
                if (full[idx])
                    rrSel = CH_W'(idx);
            end
        end
    end

    // A stalled word keeps its slot so late captures cannot change out_ch/out_data.
    assign sel = lockVld ? lockCh : rrSel;

    always_ff @(posedge clkB) begin
        if (rstB) begin
            rr      <= '0;
            lockVld <= 1'b0;
            lockCh  <= '0;
        end else begin
            lockVld <= out_valid & ~out_ready;
            lockCh  <= sel;
            if (accept)
                rr <= (int'(sel) == NUM_CH - 1) ? '0 : sel + CH_W'(1);
        end
    end

    assign out_valid = |full;
    assign out_ch    = sel;
    assign out_data  = hold[sel];

endmodule

// File: tb/tb_two_phase_hs_rx.sv
// Scoreboard bench for two_phase_hs_rx: per-channel FIFO model of sent words,
// ack parity model, directed latency/backpressure/fairness/reset cases plus random traffic.
module tb_two_phase_hs_rx;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int SS  = 2;

    logic           clkB = 1'b0;
    logic           rstB = 1'b1;
    logic [NCH-1:0] ReqA = '0;
    logic [NCH*W-1:0] DataA = '0;
    logic [NCH-1:0] AckA;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;

    two_phase_hs_rx #(.NUM_CH(NCH), .WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clkB      (clkB),
        .rstB      (rstB),
        .ReqA      (ReqA),
        .DataA     (DataA),
        .AckA      (AckA),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clkB = ~clkB;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]   expQ[NCH][$];
    logic [NCH-1:0] expAck = '0;
    int             acceptLog[$];
    bit             rndDone;

    bit           prevValid = 0;
    bit           prevReady = 0;
    logic [1:0]   prevCh    = '0;
    logic [W-1:0] prevData  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int qLeft();
        int n = 0;
        for (int c = 0; c < NCH; c++) n += expQ[c].size();
        return n;
    endfunction

    task automatic tick();
        @(posedge clkB);
        #1;
    endtask

    task automatic send(input int c, input logic [W-1:0] d);
        DataA[c*W +: W] = d;
        ReqA[c] = ~ReqA[c];
        expQ[c].push_back(d);
    endtask

    task automatic waitAck(input int c, input int lim);
        int k = 0;
        while (AckA[c] !== ReqA[c] && k < lim) begin
            @(negedge clkB);
            k++;
        end
        check($sformatf("ack_done_ch%0d", c), AckA[c], ReqA[c]);
    endtask

    task automatic resetDut();
        tick();
        rstB = 1'b1;
        ReqA = '0;
        for (int c = 0; c < NCH; c++) expQ[c].delete();
        expAck = '0;
        repeat (2) @(posedge clkB);
        #1 rstB = 1'b0;
    endtask

    task automatic drainAll(input int lim);
        int k = 0;
        tick();
        out_ready = 1'b1;
        while (qLeft() != 0 && k < lim) begin
            @(negedge clkB);
            k++;
        end
        check("drain_left", qLeft(), 0);
    endtask

    task automatic randSender(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clkB);
            tick();
            send(c, W'($urandom));
            waitAck(c, 300);
        end
    endtask

    // Monitor: every accepted word must be the oldest outstanding one of its channel.
    initial forever begin
        @(negedge clkB);
        if (rstB) begin
            prevValid = 0;
        end else begin
`ifndef TWO_PHASE_EARLY_ACK_EN
            check("ack_model", AckA, expAck);
`endif
            if (prevValid && !prevReady) begin
                check("stall_valid", out_valid, 1);
                check("stall_ch", out_ch, prevCh);
                check("stall_data", out_data, prevData);
            end
            if (out_valid && out_ready) begin
                total++;
                if (expQ[out_ch].size() == 0) begin
                    bad++;
                    $display("FAIL spurious_out: got ch=%0d data=%0h want no word", out_ch, out_data);
                end else begin
                    if (out_data !== expQ[out_ch][0]) begin
                        bad++;
                        $display("FAIL out_data ch%0d: got %0h want %0h", out_ch, out_data, expQ[out_ch][0]);
                    end
                    void'(expQ[out_ch].pop_front());
                end
                acceptLog.push_back(int'(out_ch));
                expAck[out_ch] = ~expAck[out_ch];
            end
            prevValid = out_valid;
            prevReady = out_ready;
            prevCh    = out_ch;
            prevData  = out_data;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int k;
        resetDut();
        @(negedge clkB);
        check("rst_valid", out_valid, 0);
        check("rst_ack", AckA, 0);

        // Single transfer latency on ch2
        out_ready = 1'b1;
        tick();
        send(2, 8'hA5);
        repeat (2) @(posedge clkB);
        @(negedge clkB);
        check("lat_early_valid", out_valid, 0);
        @(negedge clkB);
        check("lat_valid", out_valid, 1);
        check("lat_ch", out_ch, 2);
        check("lat_data", out_data, 8'hA5);
`ifdef TWO_PHASE_EARLY_ACK_EN
        check("lat_ack_cap", AckA[2], 1);
`else
        check("lat_ack_pre", AckA[2], 0);
`endif
        @(negedge clkB);
        check("lat_ack", AckA[2], 1);

        // Backpressure on ch1; ch0 arriving later must not displace it
        tick();
        out_ready = 1'b0;
        send(1, 8'h5A);
        k = 0;
        while (!out_valid && k < 10) begin @(negedge clkB); k++; end
        check("bp_valid", out_valid, 1);
        tick();
        send(0, 8'hC3);
        repeat (10) @(negedge clkB);
        check("bp_ch", out_ch, 1);
        check("bp_data", out_data, 8'h5A);
`ifndef TWO_PHASE_EARLY_ACK_EN
        check("bp_ack", AckA[1], 0);
`endif
        tick();
        out_ready = 1'b1;
        waitAck(1, 20);
        waitAck(0, 20);

        // Fairness from a fresh pointer
        resetDut();
        out_ready = 1'b1;
        acceptLog.delete();
        tick();
        for (int c = 0; c < NCH; c++) send(c, W'(8'h10 + c));
        for (int c = 0; c < NCH; c++) waitAck(c, 40);
        check("fair_cnt", acceptLog.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fair_ord%0d", i), (i < acceptLog.size()) ? acceptLog[i] : -1, i);
        check("fair_ack", AckA, 4'hF);
        acceptLog.delete();
        tick();
        send(0, 8'h60);
        send(3, 8'h63);
        waitAck(0, 40);
        waitAck(3, 40);
        check("fair2_cnt", acceptLog.size(), 2);
        check("fair2_ord0", (acceptLog.size() > 0) ? acceptLog[0] : -1, 0);
        check("fair2_ord1", (acceptLog.size() > 1) ? acceptLog[1] : -1, 3);

        // Back-to-back on ch0
        tick();
        send(0, 8'h11);
        waitAck(0, 40);
        tick();
        send(0, 8'h3C);
        waitAck(0, 40);
        check("b2b_ack", AckA[0], 0);
        check("b2b_left", qLeft(), 0);

        // Random traffic with random backpressure
        rndDone = 0;
        fork
            begin
                while (!rndDone) begin
                    tick();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        fork
            randSender(0, 25);
            randSender(1, 25);
            randSender(2, 25);
            randSender(3, 25);
        join
        rndDone = 1;
        drainAll(100);

        // Reset while ch1 and ch3 hold words
        tick();
        out_ready = 1'b0;
        send(1, 8'h77);
        send(3, 8'h99);
        repeat (6) @(negedge clkB);
        check("mid_full", out_valid, 1);
        resetDut();
        @(negedge clkB);
        check("mid_valid", out_valid, 0);
        check("mid_ack", AckA, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clkB);
            check("mid_idle", out_valid, 0);
        end
        acceptLog.delete();
        tick();
        send(3, 8'h42);
        waitAck(3, 40);
        check("mid_fresh_ch", (acceptLog.size() > 0) ? acceptLog[0] : -1, 3);

`ifdef TWO_PHASE_EARLY_ACK_EN
        // Early ack: ack at capture, second toggle waits for the first accept
        resetDut();
        out_ready = 1'b0;
        tick();
        send(2, 8'h21);
        repeat (2) @(posedge clkB);
        @(negedge clkB);
        check("ea_ack_pre", AckA[2], 0);
        @(negedge clkB);
        check("ea_ack_cap", AckA[2], 1);
        check("ea_valid", out_valid, 1);
        tick();
        send(2, 8'h22);
        repeat (8) @(negedge clkB);
        check("ea_hold_data", out_data, 8'h21);
        check("ea_second_pending", AckA[2], 1);
        tick();
        out_ready = 1'b1;
        waitAck(2, 40);
        drainAll(40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
